motorchannelctl: RTL and testbench

Host-facing control and register block that sits directly upstream of one brushed DC motor channel. It decodes an 8-bit register bus into the channel's control levels and strobes: PWM enable/run/polarity, tach phase inversion, duty loads, and the programmable `pwmcntce` and `filterce` clock-enable prescalers. It also sequences atomic 16-bit tach reads by snapshotting the counter and driving `freeze`.

---
 rtl/motorchannelctl.sv | 155 +++++++++++++++
 tb/tb_motorchannelctl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/motorchannelctl.sv
// Register/control block for one brushed DC motor channel: host register decode,
// duty load strobes, two clock-enable prescalers and the atomic 16-bit tach read.
module motorchannelctl #(
    parameter int unsigned FREEZE_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] address,
    input  logic       wr,
    input  logic       rd,
    input  logic [7:0] wrtdata,
    output logic [7:0] rddata,
    input  logic [7:0] countl,
    input  logic [7:0] counth,
    output logic [7:0] pwmdata,
    output logic       pwmldce,
    output logic       pwmcntce,
    output logic       filterce,
    output logic       freeze,
    output logic       invphase,
    output logic       invertpwm,
    output logic       enablepwm,
    output logic       run
);

    localparam logic [2:0] ADDR_CTRL    = 3'd0;
    localparam logic [2:0] ADDR_DUTY    = 3'd1;
    localparam logic [2:0] ADDR_PWMDIV  = 3'd2;
    localparam logic [2:0] ADDR_FILTDIV = 3'd3;
    localparam logic [2:0] ADDR_TACHL   = 3'd4;
    localparam logic [2:0] ADDR_TACHH   = 3'd5;
    localparam logic [2:0] ADDR_STATUS  = 3'd6;
    localparam logic [15:0] TMO_LOAD    = 16'(FREEZE_TIMEOUT);

    typedef enum logic {
        TACH_LIVE,
        TACH_FROZEN
    } tachstate_t;

    tachstate_t  state;
    tachstate_t  nextstate;
    logic [3:0]  ctrl;
    logic [7:0]  pwmdiv;
    logic [7:0]  filtdiv;
    logic [7:0]  pwmcnt;
    logic [7:0]  filtcnt;
    logic [7:0]  shadow;
    logic [15:0] tmo;
    logic [7:0]  rdvalue;
    logic        rdtachl;
    logic        rdtachh;

    assign rdtachl   = rd && (address == ADDR_TACHL);
    assign rdtachh   = rd && (address == ADDR_TACHH);
    assign freeze    = (state == TACH_FROZEN);
    assign enablepwm = ctrl[0];
    assign run       = ctrl[1];
    assign invertpwm = ctrl[2];
    assign invphase  = ctrl[3];
    assign pwmcntce  = (pwmcnt == 8'd0);
    assign filterce  = (filtcnt == 8'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= TACH_LIVE;
        end else begin
            state <= nextstate;
        end
    end

    // A TACHL read (re)arms the freeze; TACHH read or timeout expiry releases it.
    always_comb begin
        nextstate = state;
        case (state)
            TACH_LIVE: begin
                if (rdtachl) nextstate = TACH_FROZEN;
            end
            TACH_FROZEN: begin
                if (rdtachl)            nextstate = TACH_FROZEN;
                else if (rdtachh)       nextstate = TACH_LIVE;
                else if (tmo == 16'd1)  nextstate = TACH_LIVE;
            end
            default: nextstate = TACH_LIVE;
        endcase
    end

    always_comb begin
        rdvalue = 8'h00;
        case (address)
            ADDR_CTRL:    rdvalue = {4'h0, ctrl};
            ADDR_DUTY:    rdvalue = pwmdata;
            ADDR_PWMDIV:  rdvalue = pwmdiv;
            ADDR_FILTDIV: rdvalue = filtdiv;
            ADDR_TACHL:   rdvalue = countl;
            ADDR_TACHH:   rdvalue = freeze ? shadow : counth;
            ADDR_STATUS:  rdvalue = {7'h00, freeze};
            default:      rdvalue = 8'h00;
        endcase
    end

    // Read data is taken from pre-edge register values, so a same-cycle write is not visible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rddata  <= 8'h00;
            ctrl    <= 4'h0;
            pwmdata <= 8'h00;
            pwmldce <= 1'b0;
            pwmdiv  <= 8'h00;
            filtdiv <= 8'h00;
        end else begin
            if (rd) rddata <= rdvalue;
            pwmldce <= wr && (address == ADDR_DUTY);
            if (wr) begin
                case (address)
                    ADDR_CTRL:    ctrl    <= wrtdata[3:0];
                    ADDR_DUTY:    pwmdata <= wrtdata;
                    ADDR_PWMDIV:  pwmdiv  <= wrtdata;
                    ADDR_FILTDIV: filtdiv <= wrtdata;
                    default:      ;
                endcase
            end
        end
    end

    // Prescalers: writing a divisor restarts its counter so the next pulse is a full period away.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwmcnt  <= 8'h00;
            filtcnt <= 8'h00;
        end else begin
            if (wr && (address == ADDR_PWMDIV))  pwmcnt <= wrtdata;
            else if (pwmcnt == 8'd0)             pwmcnt <= pwmdiv;
            else                                 pwmcnt <= pwmcnt - 8'd1;

            if (wr && (address == ADDR_FILTDIV)) filtcnt <= wrtdata;
            else if (filtcnt == 8'd0)            filtcnt <= filtdiv;
            else                                 filtcnt <= filtcnt - 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow <= 8'h00;
            tmo    <= 16'd0;
        end else begin
            if (rdtachl) begin
                shadow <= counth;
                tmo    <= TMO_LOAD;
            end else if (freeze && (tmo != 16'd0)) begin
                tmo <= tmo - 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_motorchannelctl.sv
// Directed bench for motorchannelctl; read data and duty loads are checked by queue-based monitors.
module tb_motorchannelctl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] address = 3'd0;
    logic       wr = 1'b0;
    logic       rd = 1'b0;
    logic [7:0] wrtdata = 8'h00;
    logic [7:0] rddata;
    logic [7:0] countl = 8'h00;
    logic [7:0] counth = 8'h00;
    logic [7:0] pwmdata;
    logic       pwmldce;
    logic       pwmcntce;
    logic       filterce;
    logic       freeze;
    logic       invphase;
    logic       invertpwm;
    logic       enablepwm;
    logic       run;

    int checks = 0;
    int failures = 0;
    logic [7:0] readq[$];
    logic [7:0] dutyq[$];

    motorchannelctl #(.FREEZE_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .address(address), .wr(wr), .rd(rd),
        .wrtdata(wrtdata), .rddata(rddata), .countl(countl), .counth(counth),
        .pwmdata(pwmdata), .pwmldce(pwmldce), .pwmcntce(pwmcntce),
        .filterce(filterce), .freeze(freeze), .invphase(invphase),
        .invertpwm(invertpwm), .enablepwm(enablepwm), .run(run)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%02h expected=0x%02h", name, actual, expected);
        end
    endtask

    task automatic checkBit(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%b expected=%b", name, actual, expected);
        end
    endtask

    // One bus cycle, entered and left on a falling edge; expectations go to the scoreboards.
    task automatic applyStimulus(input logic dowr, input logic dord, input logic [2:0] a,
                                 input logic [7:0] d, input logic [7:0] expread);
        address = a;
        wr      = dowr;
        rd      = dord;
        wrtdata = d;
        if (dord) readq.push_back(expread);
        if (dowr && (a == 3'd1)) dutyq.push_back(d);
        @(negedge clk);
        wr = 1'b0;
        rd = 1'b0;
    endtask

    always @(posedge clk) begin
        if (!reset && rd) begin
            #1;
            if (readq.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL rddata_unexpected actual=0x%02h expected=none", rddata);
            end else begin
                checkOutput("rddata", rddata, readq.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && pwmldce) begin
            if (dutyq.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL pwmldce_unexpected actual=1 expected=0");
            end else begin
                checkOutput("pwmdata", pwmdata, dutyq.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    logic [7:0] expall [8];

    initial begin
        repeat (2) @(negedge clk);
        checkOutput("reset_rddata", rddata, 8'h00);
        checkOutput("reset_pwmdata", pwmdata, 8'h00);
        checkBit("reset_pwmldce", pwmldce, 1'b0);
        checkBit("reset_freeze", freeze, 1'b0);
        checkOutput("reset_ctrl", {4'h0, invphase, invertpwm, run, enablepwm}, 8'h00);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkBit("first_pwmcntce", pwmcntce, 1'b1);
        checkBit("first_filterce", filterce, 1'b1);
        @(negedge clk);

        // Read every address after reset
        countl = 8'h34;
        counth = 8'h56;
        expall = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h34, 8'h56, 8'h00, 8'h00};
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 3'(i), 8'h00, expall[i]);
        for (int i = 0; i < 3; i++) begin
            checkBit("div0_pwmcntce", pwmcntce, 1'b1);
            checkBit("div0_filterce", filterce, 1'b1);
            @(negedge clk);
        end

        // PWMDIV=3 gives one pulse every 4 clocks; FILTDIV=0 stays high
        applyStimulus(1'b1, 1'b0, 3'd3, 8'h00, 8'h00);
        applyStimulus(1'b1, 1'b0, 3'd2, 8'h03, 8'h00);
        for (int k = 0; k < 12; k++) begin
            checkBit("div3_pwmcntce", pwmcntce, (k % 4) == 3);
            checkBit("div3_filterce", filterce, 1'b1);
            @(negedge clk);
        end
        applyStimulus(1'b0, 1'b1, 3'd2, 8'h00, 8'h03);
        applyStimulus(1'b0, 1'b1, 3'd3, 8'h00, 8'h00);

        // Back-to-back duty loads
        applyStimulus(1'b1, 1'b0, 3'd1, 8'hA5, 8'h00);
        applyStimulus(1'b1, 1'b0, 3'd1, 8'h3C, 8'h00);
        @(negedge clk);
        checkBit("duty_strobe_end", pwmldce, 1'b0);
        applyStimulus(1'b0, 1'b1, 3'd1, 8'h00, 8'h3C);

        // Atomic 16-bit tach read with the count moving in between
        countl = 8'hFF;
        counth = 8'h12;
        checkBit("tach_prefreeze", freeze, 1'b0);
        applyStimulus(1'b0, 1'b1, 3'd4, 8'h00, 8'hFF);
        checkBit("tach_frozen", freeze, 1'b1);
        countl = 8'h00;
        counth = 8'h13;
        applyStimulus(1'b0, 1'b1, 3'd6, 8'h00, 8'h01);
        applyStimulus(1'b0, 1'b1, 3'd5, 8'h00, 8'h12);
        checkBit("tach_released", freeze, 1'b0);
        applyStimulus(1'b0, 1'b1, 3'd6, 8'h00, 8'h00);

        // Timeout with no TACHH read, then a live TACHH read
        counth = 8'h20;
        applyStimulus(1'b0, 1'b1, 3'd4, 8'h00, 8'h00);
        checkBit("tmo_freeze0", freeze, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            checkBit("tmo_freeze", freeze, k < 4);
        end
        counth = 8'h21;
        applyStimulus(1'b0, 1'b1, 3'd5, 8'h00, 8'h21);
        checkBit("tmo_live_freeze", freeze, 1'b0);

        // Re-reading TACHL while frozen re-snapshots and restarts the timeout
        applyStimulus(1'b0, 1'b1, 3'd4, 8'h00, 8'h00);
        counth = 8'h40;
        repeat (2) @(negedge clk);
        applyStimulus(1'b0, 1'b1, 3'd4, 8'h00, 8'h00);
        counth = 8'h41;
        repeat (2) begin
            @(negedge clk);
            checkBit("resnap_freeze", freeze, 1'b1);
        end
        applyStimulus(1'b0, 1'b1, 3'd5, 8'h00, 8'h40);

        // Simultaneous read and write of CTRL
        applyStimulus(1'b1, 1'b1, 3'd0, 8'h0F, 8'h00);
        checkOutput("ctrl_levels", {4'h0, invphase, invertpwm, run, enablepwm}, 8'h0F);
        applyStimulus(1'b0, 1'b1, 3'd0, 8'h00, 8'h0F);
        applyStimulus(1'b1, 1'b0, 3'd0, 8'hF5, 8'h00);
        checkOutput("ctrl_levels_5", {4'h0, invphase, invertpwm, run, enablepwm}, 8'h05);
        applyStimulus(1'b0, 1'b1, 3'd0, 8'h00, 8'h05);
        applyStimulus(1'b1, 1'b0, 3'd7, 8'hFF, 8'h00);
        applyStimulus(1'b0, 1'b1, 3'd7, 8'h00, 8'h00);

        // Asynchronous reset in the middle of a tach read
        applyStimulus(1'b0, 1'b1, 3'd4, 8'h00, 8'h00);
        checkBit("arst_prefreeze", freeze, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        checkBit("arst_freeze", freeze, 1'b0);
        checkOutput("arst_ctrl", {4'h0, invphase, invertpwm, run, enablepwm}, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        counth = 8'h77;
        applyStimulus(1'b0, 1'b1, 3'd5, 8'h00, 8'h77);

        repeat (2) @(negedge clk);
        checkOutput("readq_left", 8'(readq.size()), 8'd0);
        checkOutput("dutyq_left", 8'(dutyq.size()), 8'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
